// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the in-flight transaction
//   SZ_*    : access size codes carried on dm_size / mem_size
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters, with a starvation
// counter that forces a fetch grant after STARVE_MAX back-to-back data grants.
//   clock, reset      : clock, synchronous active-high reset
//   idle              : arbiter is able to accept a request this cycle
//   if_req_valid      : fetch request pending
//   dm_req_valid      : data request pending
//   if_ready_c        : combinational fetch grant
//   dm_ready_c        : combinational data grant
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic idle,
    input  logic if_req_valid,
    input  logic dm_req_valid,
    output logic if_ready_c,
    output logic dm_ready_c
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_d;
    logic          force_if_c;

    // Data wins unless fetch has been starved long enough
    always_comb begin
        force_if_c = if_req_valid && (starve_cnt == CW'(STARVE_MAX));
        dm_ready_c = idle && dm_req_valid && !force_if_c;
        if_ready_c = idle && if_req_valid && !dm_ready_c;
    end

    // Counts data grants that happen while a fetch is waiting
    always_comb begin
        starve_d = starve_cnt;
        if (!if_req_valid || if_ready_c) begin
            starve_d = '0;
        end else if (dm_ready_c && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_d = starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters.
// One transaction in flight at a time; the response is routed back to the
// requester that was granted.
//   clock, reset                      : clock, synchronous active-high reset
//   if_req_*/if_addr                  : fetch request (ready is combinational)
//   if_rsp_valid/if_rsp_data          : fetch response pulse
//   dm_req_*/dm_addr/wdata/we/size    : data request (ready is combinational)
//   dm_rsp_valid/dm_rsp_data          : data response pulse (0 data on store)
//   mem_req_valid/mem_*               : one-cycle request to memory
//   mem_rsp_valid/mem_rsp_data        : memory response pulse
//   err                               : sticky unexpected-response flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATAW      = 32,
    parameter int unsigned ADDRW      = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [ADDRW-1:0] if_addr,
    output logic             if_rsp_valid,
    output logic [DATAW-1:0] if_rsp_data,
    input  logic             dm_req_valid,
    output logic             dm_req_ready,
    input  logic [ADDRW-1:0] dm_addr,
    input  logic [DATAW-1:0] dm_wdata,
    input  logic             dm_we,
    input  logic [1:0]       dm_size,
    output logic             dm_rsp_valid,
    output logic [DATAW-1:0] dm_rsp_data,
    output logic             mem_req_valid,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    output logic             mem_we,
    output logic [1:0]       mem_size,
    input  logic             mem_rsp_valid,
    input  logic [DATAW-1:0] mem_rsp_data,
    output logic             err
);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             store_q, store_d;
    logic             idle_c;

    logic             mem_req_valid_d;
    logic [ADDRW-1:0] mem_addr_d;
    logic [DATAW-1:0] mem_wdata_d;
    logic             mem_we_d;
    logic [1:0]       mem_size_d;
    logic             if_rsp_valid_d;
    logic [DATAW-1:0] if_rsp_data_d;
    logic             dm_rsp_valid_d;
    logic [DATAW-1:0] dm_rsp_data_d;
    logic             err_d;

    assign idle_c = (state_q == ST_IDLE);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clock        (clock),
        .reset        (reset),
        .idle         (idle_c),
        .if_req_valid (if_req_valid),
        .dm_req_valid (dm_req_valid),
        .if_ready_c   (if_req_ready),
        .dm_ready_c   (dm_req_ready)
    );

    // Next state and next registered outputs; the mem_* registers double as
    // the request latch, the rsp_* registers as the response latch.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        store_d         = store_q;
        mem_req_valid_d = 1'b0;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
        mem_we_d        = 1'b0;
        mem_size_d      = '0;
        if_rsp_valid_d  = 1'b0;
        if_rsp_data_d   = '0;
        dm_rsp_valid_d  = 1'b0;
        dm_rsp_data_d   = '0;
        // A response is only legal while waiting for one
        err_d           = err || (mem_rsp_valid && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (dm_req_ready) begin
                    state_d         = ST_REQ;
                    owner_d         = OWN_DM;
                    store_d         = dm_we;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = dm_addr;
                    mem_wdata_d     = dm_wdata;
                    mem_we_d        = dm_we;
                    mem_size_d      = dm_size;
                end else if (if_req_ready) begin
                    state_d         = ST_REQ;
                    owner_d         = OWN_IF;
                    store_d         = 1'b0;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = if_addr;
                    mem_size_d      = SZ_WORD;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_rsp_valid_d = 1'b1;
                        dm_rsp_data_d  = store_q ? '0 : mem_rsp_data;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = mem_rsp_data;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            store_q       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_size      <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            dm_rsp_valid  <= 1'b0;
            dm_rsp_data   <= '0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            store_q       <= store_d;
            mem_req_valid <= mem_req_valid_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            mem_we        <= mem_we_d;
            mem_size      <= mem_size_d;
            if_rsp_valid  <= if_rsp_valid_d;
            if_rsp_data   <= if_rsp_data_d;
            dm_rsp_valid  <= dm_rsp_valid_d;
            dm_rsp_data   <= dm_rsp_data_d;
            err           <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .DATAW      (32),
        .ADDRW      (32),
        .STARVE_MAX (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_we         (dm_we),
        .dm_size       (dm_size),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_data   (dm_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational readys settle after an input change
    task automatic settle();
        #1;
    endtask

    // Called in the REQ cycle: memory answers k cycles later with a one-cycle
    // pulse; returns in the RESP cycle.
    task automatic mem_reply(input int k, input logic [31:0] data);
        repeat (k) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        settle();
        checks++;
        if ({mem_req_valid, mem_we, if_rsp_valid, dm_rsp_valid, err, if_req_ready, dm_req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 0000000",
                     {mem_req_valid, mem_we, if_rsp_valid, dm_rsp_valid, err, if_req_ready, dm_req_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_size, if_rsp_data, dm_rsp_data} !== 130'b0) begin
            errors++;
            $display("FAIL reset_buses: addr=%h wdata=%h size=%0d ifd=%h dmd=%h exp all 0",
                     mem_addr, mem_wdata, mem_size, if_rsp_data, dm_rsp_data);
        end
        checks++;
        if (dut.u_pick.starve_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_starve: got %0d exp 0", dut.u_pick.starve_cnt);
        end
    endtask

    task automatic test_fetch();
        if_addr      = 32'h0100_0000;
        if_req_valid = 1'b1;
        settle();
        checks++;
        if ({if_req_ready, dm_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_ready: got if/dm=%b exp 10", {if_req_ready, dm_req_ready});
        end
        tick();
        if_req_valid = 1'b0;
        if_addr      = '0;
        checks++;
        if ({mem_req_valid, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'd2, 32'h0100_0000, 32'h0}) begin
            errors++;
            $display("FAIL fetch_memreq: got v=%b we=%b sz=%0d a=%h wd=%h exp v=1 we=0 sz=2 a=01000000 wd=0",
                     mem_req_valid, mem_we, mem_size, mem_addr, mem_wdata);
        end
        mem_reply(2, 32'h0000_0013);
        checks++;
        if ({if_rsp_valid, if_rsp_data, dm_rsp_valid} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            errors++;
            $display("FAIL fetch_rsp: got ifv=%b d=%h dmv=%b exp ifv=1 d=00000013 dmv=0",
                     if_rsp_valid, if_rsp_data, dm_rsp_valid);
        end
        tick();
        checks++;
        if ({if_rsp_valid, mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_pulse: got ifv/memv=%b exp 00", {if_rsp_valid, mem_req_valid});
        end
    endtask

    task automatic test_store();
        dm_addr      = 32'h0100_0100;
        dm_wdata     = 32'hDEAD_BEEF;
        dm_we        = 1'b1;
        dm_size      = 2'd2;
        dm_req_valid = 1'b1;
        settle();
        checks++;
        if ({dm_req_ready, if_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL store_ready: got dm/if=%b exp 10", {dm_req_ready, if_req_ready});
        end
        tick();
        dm_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'd2, 32'h0100_0100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_memreq: got v=%b we=%b sz=%0d a=%h wd=%h exp v=1 we=1 sz=2 a=01000100 wd=deadbeef",
                     mem_req_valid, mem_we, mem_size, mem_addr, mem_wdata);
        end
        mem_reply(1, 32'hCAFE_F00D);
        checks++;
        if ({dm_rsp_valid, dm_rsp_data, if_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_ack: got dmv=%b d=%h ifv=%b exp dmv=1 d=0 ifv=0",
                     dm_rsp_valid, dm_rsp_data, if_rsp_valid);
        end
        tick();
        dm_we = 1'b0;
    endtask

    task automatic test_simultaneous();
        if_addr      = 32'h0100_0004;
        dm_addr      = 32'h0100_0200;
        dm_we        = 1'b0;
        dm_size      = 2'd0;
        if_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        settle();
        checks++;
        if ({dm_req_ready, if_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_pick: got dm/if=%b exp 10", {dm_req_ready, if_req_ready});
        end
        tick();
        dm_req_valid = 1'b0;
        settle();
        checks++;
        if ({if_req_ready, dm_req_ready, mem_addr, mem_size, mem_we} !== {2'b00, 32'h0100_0200, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL simul_dmreq: got rdy=%b a=%h sz=%0d we=%b exp rdy=00 a=01000200 sz=0 we=0",
                     {if_req_ready, dm_req_ready}, mem_addr, mem_size, mem_we);
        end
        mem_reply(3, 32'h0000_00A5);
        checks++;
        if ({dm_rsp_valid, dm_rsp_data, if_rsp_valid} !== {1'b1, 32'h0000_00A5, 1'b0}) begin
            errors++;
            $display("FAIL simul_dmrsp: got dmv=%b d=%h ifv=%b exp dmv=1 d=000000a5 ifv=0",
                     dm_rsp_valid, dm_rsp_data, if_rsp_valid);
        end
        tick();
        settle();
        checks++;
        if ({if_req_ready, dm_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_ifgrant: got if/dm=%b exp 10", {if_req_ready, dm_req_ready});
        end
        tick();
        if_req_valid = 1'b0;
        checks++;
        if ({mem_addr, mem_size} !== {32'h0100_0004, 2'd2}) begin
            errors++;
            $display("FAIL simul_ifreq: got a=%h sz=%0d exp a=01000004 sz=2", mem_addr, mem_size);
        end
        mem_reply(1, 32'h0010_0093);
        checks++;
        if ({if_rsp_valid, if_rsp_data, dm_rsp_valid} !== {1'b1, 32'h0010_0093, 1'b0}) begin
            errors++;
            $display("FAIL simul_ifrsp: got ifv=%b d=%h dmv=%b exp ifv=1 d=00100093 dmv=0",
                     if_rsp_valid, if_rsp_data, dm_rsp_valid);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic        exp_dm;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        if_addr      = 32'h0100_0400;
        if_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        dm_we        = 1'b0;
        dm_size      = 2'd2;
        for (int i = 0; i < 6; i++) begin
            exp_dm   = (i != 4);
            dm_addr  = 32'h0100_0300 + 32'(i * 4);
            exp_addr = exp_dm ? dm_addr : if_addr;
            rdata    = 32'h0000_0100 + 32'(i);
            settle();
            if (i == 4) begin
                checks++;
                if (dut.u_pick.starve_cnt !== 3'd4) begin
                    errors++;
                    $display("FAIL starve_full: got %0d exp 4", dut.u_pick.starve_cnt);
                end
            end
            checks++;
            if ({dm_req_ready, if_req_ready} !== {exp_dm, !exp_dm}) begin
                errors++;
                $display("FAIL starve_grant%0d: got dm/if=%b exp %b",
                         i, {dm_req_ready, if_req_ready}, {exp_dm, !exp_dm});
            end
            tick();
            checks++;
            if ({if_req_ready, dm_req_ready, mem_addr} !== {2'b00, exp_addr}) begin
                errors++;
                $display("FAIL starve_req%0d: got rdy=%b a=%h exp rdy=00 a=%h",
                         i, {if_req_ready, dm_req_ready}, mem_addr, exp_addr);
            end
            if (i == 4) begin
                checks++;
                if (dut.u_pick.starve_cnt !== 3'd0) begin
                    errors++;
                    $display("FAIL starve_clear: got %0d exp 0", dut.u_pick.starve_cnt);
                end
            end
            mem_reply(1, rdata);
            checks++;
            if ({dm_rsp_valid, if_rsp_valid, (exp_dm ? dm_rsp_data : if_rsp_data)} !== {exp_dm, !exp_dm, rdata}) begin
                errors++;
                $display("FAIL starve_rsp%0d: got dmv=%b ifv=%b dmd=%h ifd=%h exp dmv=%b data=%h",
                         i, dm_rsp_valid, if_rsp_valid, dm_rsp_data, if_rsp_data, exp_dm, rdata);
            end
            tick();
        end
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        if_addr      = 32'h0100_0008;
        if_req_valid = 1'b1;
        tick();
        if_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({err, mem_req_valid, if_rsp_valid, dm_rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear: got err/memv/ifv/dmv=%b exp 0000",
                     {err, mem_req_valid, if_rsp_valid, dm_rsp_valid});
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0BAD;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        checks++;
        if ({err, if_rsp_valid, dm_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_late: got err/ifv/dmv=%b exp 100", {err, if_rsp_valid, dm_rsp_valid});
        end
        tick();
        checks++;
        if ({err, if_rsp_valid, dm_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_hold: got err/ifv/dmv=%b exp 100", {err, if_rsp_valid, dm_rsp_valid});
        end
        if_addr      = 32'h0100_000C;
        if_req_valid = 1'b1;
        settle();
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b exp 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        mem_reply(2, 32'h0000_0073);
        checks++;
        if ({if_rsp_valid, if_rsp_data, dm_rsp_valid} !== {1'b1, 32'h0000_0073, 1'b0}) begin
            errors++;
            $display("FAIL midrst_fetch: got ifv=%b d=%h dmv=%b exp ifv=1 d=00000073 dmv=0",
                     if_rsp_valid, if_rsp_data, dm_rsp_valid);
        end
        tick();
    endtask

    task automatic test_idle_rsp();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL idle_rst0: got err=%b exp 0", err);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0055;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        checks++;
        if ({err, if_rsp_valid, dm_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL idle_err: got err/ifv/dmv=%b exp 100", {err, if_rsp_valid, dm_rsp_valid});
        end
        repeat (3) tick();
        checks++;
        if ({err, if_rsp_valid, dm_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL idle_sticky: got err/ifv/dmv=%b exp 100", {err, if_rsp_valid, dm_rsp_valid});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL idle_rst1: got err=%b exp 0", err);
        end
    endtask

    initial begin
        reset         = 1'b1;
        if_req_valid  = 1'b0;
        if_addr       = '0;
        dm_req_valid  = 1'b0;
        dm_addr       = '0;
        dm_wdata      = '0;
        dm_we         = 1'b0;
        dm_size       = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_idle_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified backing memory between the fetch requester (PC-side instruction reads) and the data requester (load/store from the MEM stage).
- Grants one transaction at a time, with at most one outstanding request, and routes each response back to the requester that issued it.
- Data accesses have priority. A starvation counter guarantees fetch forward progress.
- Sits between the core pipeline and the memory model; its ready signals feed the core's stall logic.

Parameters:
- DATAW, 32, data width of all data buses
- ADDRW, 32, address width
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- if_req_valid  input  1  fetch request
- if_req_ready  output  1  fetch request accepted this cycle
- if_addr  input  ADDRW  fetch address
- if_rsp_valid  output  1  fetch response pulse
- if_rsp_data  output  DATAW  fetched instruction
- dm_req_valid  input  1  data request
- dm_req_ready  output  1  data request accepted this cycle
- dm_addr  input  ADDRW  data address
- dm_wdata  input  DATAW  store data
- dm_we  input  1  1 = store, 0 = load
- dm_size  input  2  access size (byte/half/word), passed through
- dm_rsp_valid  output  1  data response pulse (load data or store ack)
- dm_rsp_data  output  DATAW  load data; 0 for store ack
- mem_req_valid  output  1  request to memory, one-cycle pulse
- mem_addr  output  ADDRW  memory address
- mem_wdata  output  DATAW  memory write data
- mem_we  output  1  memory write enable
- mem_size  output  2  memory access size
- mem_rsp_valid  input  1  memory response pulse (reads and writes)
- mem_rsp_data  input  DATAW  memory read data
- err  output  1  sticky protocol error flag

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. The owner register (IF or DM) is captured on acceptance.
- Grant logic (combinational, IDLE only):
  - force_if = if_req_valid && starve_cnt == STARVE_MAX.
  - dm_req_ready = IDLE && dm_req_valid && !force_if.
  - if_req_ready = IDLE && if_req_valid && !dm_req_ready.
  - Both readys are 0 in all other states.
- Acceptance (valid && ready) in IDLE: latch the address and data fields, set owner, go to REQ.
- REQ (exactly 1 cycle):
  - mem_req_valid=1 and mem_* driven from the latched fields.
  - For an IF owner: mem_we=0, mem_size=2'b10, mem_wdata=0.
  - Go to WAIT.
- WAIT:
  - Hold until mem_rsp_valid. Latch mem_rsp_data, or 0 if the owner was DM with we=1. Go to RESP.
  - No timeout; memory latency is unbounded and at least 1 cycle.
- RESP (exactly 1 cycle):
  - The owner's rsp_valid=1 and rsp_data driven from the latch; the other requester's rsp_valid=0.
  - Go to IDLE.
- Latency: accept at cycle t; mem_req at t+1; mem_rsp at t+1+k (k≥1); rsp_valid at t+2+k. Next acceptance is possible no earlier than t+3+k.
- starve_cnt (width clog2(STARVE_MAX+1)), updated on DM acceptance only:
  - On a DM grant while if_req_valid=1: increment, saturating at STARVE_MAX.
  - On any IF grant, or any cycle with if_req_valid=0: clear to 0.
- Requesters must hold valid and their fields stable until ready. Fields are sampled only on acceptance.
- mem_rsp_valid in IDLE, REQ or RESP: ignored for data, and sets err. err clears only on reset.
- Simultaneous if and dm valid with starve_cnt < STARVE_MAX: DM wins. At STARVE_MAX: IF wins and the counter clears.
- Reset values:
  - State IDLE, starve_cnt 0, err 0.
  - All *_valid and *_ready outputs 0; all data and address outputs 0.
- Reset mid-transaction returns to IDLE and drops the outstanding response; a late mem_rsp_valid after reset sets err.
- All outputs except if_req_ready and dm_req_ready are registered.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding localparams (IDLE, REQ, WAIT, RESP).
  - Owner encoding (OWN_IF, OWN_DM).
  - Size constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
- One sub-module mem_arb_pick: combinational grant plus the starve_cnt register, with inputs if/dm valid and idle and outputs the two readys.
- The FSM and datapath latches stay in the top level.

Test Plan:
- Lone fetch, if_addr=0x01000000, memory k=2 returns 0x00000013:
  - if_req_ready at t, mem_req_valid at t+1 with mem_we=0 and mem_size=2.
  - if_rsp_valid=1 with data 0x00000013 at t+4; dm_rsp_valid stays 0.
- Store, dm_addr=0x01000100, wdata=0xDEADBEEF, size=2, k=1:
  - mem_we=1, mem_wdata=0xDEADBEEF at t+1.
  - dm_rsp_valid at t+3 with dm_rsp_data=0.
- Simultaneous if and dm requests, starve_cnt=0: dm_req_ready=1 and if_req_ready=0. After the DM completes, the IF is granted at the next IDLE if DM is idle.
- Continuous dm_req_valid and if_req_valid, STARVE_MAX=4:
  - Grant order is DM, DM, DM, DM, IF, DM…
  - starve_cnt reads 0 after the IF grant.
- Reset asserted in WAIT, then mem_rsp_valid 2 cycles later:
  - No rsp_valid on either port; err=1.
  - A new fetch then completes normally.
- mem_rsp_valid pulsed in IDLE with no request: err=1 and stays 1 until reset; no rsp_valid on either port.
